// File: rtl/aes_req_arb.sv
// Two-requester round-robin front end for a single AES core: grants one request, starts the
// core, waits for completion or timeout, and returns the result with a one-cycle ack.
module aes_req_arb #(
    parameter int unsigned P_TIMEOUT = 40
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iReq0,
    input  logic         iReq1,
    input  logic [127:0] iData0,
    input  logic [127:0] iData1,
    output logic         oStAes,
    output logic [127:0] oAesData,
    input  logic         iAesDone,
    input  logic [127:0] iAesResult,
    output logic [127:0] oResult,
    output logic         oAck0,
    output logic         oAck1,
    output logic         oErr,
    output logic         oBusy,
    output logic         oGntId
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    localparam logic [5:0] TMO = 6'(P_TIMEOUT);

    state_t       state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    logic         last_q, last_d;
    logic         gnt_q, gnt_d;
    logic         err_q, err_d;
    logic [127:0] aes_data_q, aes_data_d;
    logic [127:0] result_q, result_d;
    logic         st_q, st_d;
    logic         ack0_q, ack0_d;
    logic         ack1_q, ack1_d;
    logic         err_out_q, err_out_d;
    logic         busy_q, busy_d;
    logic         win;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        err_d      = err_q;
        aes_data_d = aes_data_q;
        result_d   = result_q;
        win        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (iReq0 || iReq1) begin
                    win        = (iReq0 && iReq1) ? ~last_q : iReq1;
                    gnt_d      = win;
                    aes_data_d = win ? iData1 : iData0;
                    cnt_d      = '0;
                    state_d    = S_START;
                end
            end
            // The counter holds the number of WAIT cycles including the current one, so
            // WAIT lasts at most P_TIMEOUT cycles.
            S_START: begin
                cnt_d   = cnt_q + 6'd1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (iAesDone) begin
                    result_d = iAesResult;
                    err_d    = 1'b0;
                    state_d  = S_ACK;
                end else if (cnt_q >= TMO) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_ACK;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_ACK: begin
                last_d  = gnt_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        st_d      = (state_d == S_START);
        ack0_d    = (state_d == S_ACK) && !gnt_d;
        ack1_d    = (state_d == S_ACK) && gnt_d;
        err_out_d = (state_d == S_ACK) && err_d;
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            gnt_q      <= 1'b0;
            err_q      <= 1'b0;
            aes_data_q <= '0;
            result_q   <= '0;
            st_q       <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            err_out_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            err_q      <= err_d;
            aes_data_q <= aes_data_d;
            result_q   <= result_d;
            st_q       <= st_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            err_out_q  <= err_out_d;
            busy_q     <= busy_d;
        end
    end

    assign oStAes   = st_q;
    assign oAesData = aes_data_q;
    assign oResult  = result_q;
    assign oAck0    = ack0_q;
    assign oAck1    = ack1_q;
    assign oErr     = err_out_q;
    assign oBusy    = busy_q;
    assign oGntId   = gnt_q;

endmodule

// File: tb/tb_aes_req_arb.sv
// Bench for aes_req_arb: directed scenarios plus randomized traffic, every cycle compared
// against an operation-level model of the arbiter.
module tb_aes_req_arb;

    localparam int TMO = 40;

    logic         iClk = 1'b0;
    logic         iRst = 1'b1;
    logic         iReq0 = 1'b0, iReq1 = 1'b0;
    logic [127:0] iData0 = '0, iData1 = '0;
    logic         oStAes;
    logic [127:0] oAesData;
    logic         iAesDone = 1'b0;
    logic [127:0] iAesResult = '0;
    logic [127:0] oResult;
    logic         oAck0, oAck1, oErr, oBusy, oGntId;

    always #5 iClk = ~iClk;

    aes_req_arb #(.P_TIMEOUT(TMO)) dut (
        .iClk(iClk), .iRst(iRst), .iReq0(iReq0), .iReq1(iReq1),
        .iData0(iData0), .iData1(iData1), .oStAes(oStAes), .oAesData(oAesData),
        .iAesDone(iAesDone), .iAesResult(iAesResult), .oResult(oResult),
        .oAck0(oAck0), .oAck1(oAck1), .oErr(oErr), .oBusy(oBusy), .oGntId(oGntId)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: one operation at a time; m_age = -1 when no operation, 0 in the start cycle,
    // k >= 1 in the k-th cycle of waiting for the core.
    bit           m_valid = 0;
    int           m_age = -1;
    bit           m_acking = 0, m_last = 1, m_gnt = 0, m_err = 0;
    logic [127:0] m_data = '0, m_result = '0;

    // Environment knobs
    bit           keep0 = 0, keep1 = 0, auto0 = 0, auto1 = 0;
    bit           rand_lat = 0, spur_en = 0, use_fixed = 0, rst_rand = 0;
    int           lat = 5;
    int           done_at = -1;
    logic [127:0] fixed_res = '0;
    int           st_cyc = -1, ack_cyc = -1;
    bit           ack_log[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_step();
        if (iRst) begin
            m_valid = 1; m_age = -1; m_acking = 0; m_last = 1; m_gnt = 0; m_err = 0;
            m_data = '0; m_result = '0;
        end else if (m_acking) begin
            m_acking = 0;
            m_last   = m_gnt;
        end else if (m_age < 0) begin
            if (iReq0 || iReq1) begin
                m_gnt  = (iReq0 && iReq1) ? !m_last : iReq1;
                m_data = m_gnt ? iData1 : iData0;
                m_age  = 0;
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (iAesDone) begin
            m_result = iAesResult; m_err = 0; m_acking = 1; m_age = -1;
        end else if (m_age == TMO) begin
            m_result = '0; m_err = 1; m_acking = 1; m_age = -1;
        end else begin
            m_age++;
        end
    endtask

    task automatic compare();
        if (m_valid) begin
            chk("st",     oStAes,   m_age == 0);
            chk("busy",   oBusy,    (m_age >= 0) || m_acking);
            chk("ack0",   oAck0,    m_acking && !m_gnt);
            chk("ack1",   oAck1,    m_acking && m_gnt);
            chk("err",    oErr,     m_acking && m_err);
            chk("gnt",    oGntId,   m_gnt);
            chk("data",   oAesData, m_data);
            chk("result", oResult,  m_result);
        end
    endtask

    task automatic tick();
        int l;
        @(posedge iClk);
        model_step();
        #1;
        cyc++;
        compare();
        if (oStAes) begin
            st_cyc = cyc;
            if (rand_lat) l = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(TMO + 5, 1));
            else          l = lat;
            done_at = (l == 0) ? -1 : cyc + l;
        end
        if (oAck0 || oAck1) begin
            ack_cyc = cyc;
            ack_log.push_back(oAck1);
        end
        if (oAck0) begin
            iReq0 = keep0;
            if (keep0) iData0 = rnd128();
        end else if (!iReq0 && auto0 && $urandom_range(3) == 0) begin
            iReq0 = 1'b1; iData0 = rnd128();
        end
        if (oAck1) begin
            iReq1 = keep1;
            if (keep1) iData1 = rnd128();
        end else if (!iReq1 && auto1 && $urandom_range(3) == 0) begin
            iReq1 = 1'b1; iData1 = rnd128();
        end
        iAesDone   = (cyc == done_at) || (spur_en && m_age < 1 && $urandom_range(7) == 0);
        iAesResult = use_fixed ? fixed_res : rnd128();
        iRst       = rst_rand && ($urandom_range(299) == 0);
    endtask

    task automatic wait_ack(input int bound);
        int n = 0;
        while (!(oAck0 || oAck1) && n < bound) begin
            tick();
            n++;
        end
        if (!(oAck0 || oAck1)) chk("ack_wait_timeout", oAck0 | oAck1, 1'b1);
    endtask

    initial begin
        logic [127:0] kdata, kres, cres;
        int c0, idle, nack, n;
        kdata = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        kres  = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;
        cres  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

        // Reset values
        iRst = 1'b1;
        tick();
        chk("rst_busy", oBusy, 1'b0);
        chk("rst_gnt", oGntId, 1'b0);
        chk("rst_result", oResult, '0);
        chk("rst_aesdata", oAesData, '0);
        tick();

        // Single request with the known vector
        use_fixed = 1; fixed_res = kres; lat = 11;
        iReq0 = 1'b1; iData0 = kdata; c0 = cyc; st_cyc = -1;
        wait_ack(100);
        chk("single_req2st", st_cyc - c0, 1);
        chk("single_lat", ack_cyc - st_cyc, 12);
        chk("single_ack0", oAck0, 1'b1);
        chk("single_result", oResult, kres);
        chk("single_err", oErr, 1'b0);
        chk("single_aesdata", oAesData, kdata);
        tick();

        // Tie right after reset: requester 0 first
        iRst = 1'b1;
        tick();
        use_fixed = 0; lat = 5;
        iReq0 = 1'b1; iReq1 = 1'b1; iData0 = rnd128(); iData1 = rnd128();
        ack_log.delete();
        wait_ack(50);
        tick();
        wait_ack(50);
        chk("tie_count", ack_log.size(), 2);
        if (ack_log.size() >= 2) begin
            chk("tie_first", ack_log[0], 1'b0);
            chk("tie_second", ack_log[1], 1'b1);
        end
        tick();

        // Fairness with both held
        keep0 = 1; keep1 = 1; lat = 3;
        iReq0 = 1'b1; iReq1 = 1'b1;
        ack_log.delete(); idle = 0; n = 0;
        while (ack_log.size() < 4 && n < 200) begin
            tick();
            n++;
            if (ack_log.size() >= 1 && ack_log.size() < 4 && !oBusy) idle++;
        end
        chk("fair_count", ack_log.size(), 4);
        if (ack_log.size() >= 4) begin
            chk("fair_0", ack_log[0], 1'b0);
            chk("fair_1", ack_log[1], 1'b1);
            chk("fair_2", ack_log[2], 1'b0);
            chk("fair_3", ack_log[3], 1'b1);
        end
        chk("fair_idle_gaps", idle, 3);
        keep0 = 0; keep1 = 0; iReq0 = 1'b0; iReq1 = 1'b0;
        tick();

        // Timeout
        lat = 0; iReq1 = 1'b1; iData1 = rnd128(); st_cyc = -1;
        wait_ack(100);
        chk("tmo_lat", ack_cyc - st_cyc, TMO + 1);
        chk("tmo_ack1", oAck1, 1'b1);
        chk("tmo_err", oErr, 1'b1);
        chk("tmo_result", oResult, '0);
        tick();

        // Done in the same cycle as the timeout
        use_fixed = 1; fixed_res = cres; lat = TMO;
        iReq0 = 1'b1; iData0 = rnd128(); st_cyc = -1;
        wait_ack(100);
        chk("coll_lat", ack_cyc - st_cyc, TMO + 1);
        chk("coll_err", oErr, 1'b0);
        chk("coll_result", oResult, cres);
        tick();

        // Reset while waiting for the core
        lat = 0; iReq0 = 1'b1; iData0 = rnd128(); st_cyc = -1; n = 0;
        while (st_cyc < 0 && n < 10) begin
            tick();
            n++;
        end
        chk("rstw_started", oStAes, 1'b1);
        tick(); tick(); tick();
        iRst = 1'b1; iReq0 = 1'b0; done_at = cyc + 3;
        tick();
        chk("rstw_busy", oBusy, 1'b0);
        nack = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (oAck0 || oAck1 || oBusy) nack++;
        end
        chk("rstw_quiet", nack, 0);
        lat = 7; iReq0 = 1'b1; iData0 = rnd128(); st_cyc = -1;
        wait_ack(50);
        chk("rstw_again_ack0", oAck0, 1'b1);
        chk("rstw_again_lat", ack_cyc - st_cyc, 8);
        chk("rstw_again_result", oResult, cres);
        tick();

        // Randomized traffic
        use_fixed = 0; rand_lat = 1; spur_en = 1; auto0 = 1; auto1 = 1; rst_rand = 1;
        for (int blk = 0; blk < 6; blk++) begin
            keep0 = 1'($urandom_range(1));
            keep1 = 1'($urandom_range(1));
            for (int i = 0; i < 600; i++) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_req_arb.md
AES_REQ_ARB -- requirements
Module: aes_req_arb

Interface
REQ-001 Parameter: P_TIMEOUT, default 40, maximum cycles spent in WAIT before abort (legal range 1..63).
REQ-002 iClk  input  1  sole clock; all state updates on rising edge.
REQ-003 iRst  input  1  reset, synchronous, active-high.
REQ-004 iReq0  input  1  requester 0 operation request; held high until oAck0.
REQ-005 iReq1  input  1  requester 1 operation request; held high until oAck1.
REQ-006 iData0  input  128  requester 0 input block; stable while iReq0 high.
REQ-007 iData1  input  128  requester 1 input block; stable while iReq1 high.
REQ-008 oStAes  output  1  one-cycle start pulse to AES core.
REQ-009 oAesData  output  128  registered input block presented to AES core.
REQ-010 iAesDone  input  1  AES core completion pulse.
REQ-011 iAesResult  input  128  AES core result; valid in the iAesDone cycle.
REQ-012 oResult  output  128  registered result returned to the granted requester.
REQ-013 oAck0  output  1  one-cycle completion pulse to requester 0.
REQ-014 oAck1  output  1  one-cycle completion pulse to requester 1.
REQ-015 oErr  output  1  timeout flag; high only together with oAck0 or oAck1.
REQ-016 oBusy  output  1  high in every state except IDLE.
REQ-017 oGntId  output  1  ID of current or last granted requester.

Function
REQ-018 FSM states: IDLE, START, WAIT, ACK; all outputs are registered or decoded from state only.
REQ-019 IDLE: requests sampled only here; no request -> stay IDLE.
REQ-020 Arbitration: round-robin over rLast (last served ID); one request -> grant it; both -> grant !rLast.
REQ-021 On grant: oGntId <= winner; oAesData <= winner's iData; wait counter <= 0; next state START.
REQ-022 START: oStAes = 1 for exactly this one cycle; next state WAIT.
REQ-023 WAIT: counter increments by 1 each cycle; iAesDone = 1 -> oResult <= iAesResult, error flag <= 0, next ACK.
REQ-024 WAIT: counter == P_TIMEOUT with iAesDone = 0 -> oResult <= 0, error flag <= 1, next ACK.
REQ-025 Timeout and iAesDone in the same cycle: completion wins, oErr = 0.
REQ-026 ACK: ack of oGntId = 1 for one cycle; oErr = error flag; rLast <= oGntId; next IDLE.
REQ-027 Requester drops its request on the edge after its ack; a request still high in the next IDLE cycle is a new request.
REQ-028 iAesDone in IDLE, START or ACK is ignored; no state or output change.
REQ-029 Request edges while not in IDLE are not lost: they are evaluated at the next IDLE cycle.
REQ-030 Latency: request sampled in IDLE cycle N -> oStAes in N+1; done in cycle D -> ack in D+1.
REQ-031 Back-to-back: both requesters continuously requesting are served alternately, no idle gap beyond the single IDLE cycle.
REQ-032 oAesData and oResult hold their values until next overwrite.
REQ-033 Counter is 6 bits wide and never wraps; it is cleared on every grant.

Reset
REQ-034 iRst = 1 at any clock edge, including mid-operation -> state IDLE; counter 0; rLast 1 (requester 0 wins first tie); oGntId 0.
REQ-035 Reset values: oStAes, oAck0, oAck1, oErr and oBusy 0; oAesData and oResult all-zero.
REQ-036 Reset mid-operation issues no ack; the in-flight operation is discarded and the requester must re-request.

Verification
REQ-037 Single request: iReq0 = 1, iData0 = 128'h00112233_44556677_8899AABB_CCDDEEFF; core returns done 11 cycles after oStAes with result 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A -> oAck0 one cycle later, oResult equals that value, oErr = 0.
REQ-038 Tie after reset: iReq0 = iReq1 = 1 in the same IDLE cycle -> requester 0 granted first, then requester 1; oGntId sequence 0, 1.
REQ-039 Fairness: both requests held for 4 operations -> ack sequence 0, 1, 0, 1; oBusy low for exactly one cycle between operations.
REQ-040 Timeout: P_TIMEOUT = 40, iAesDone never asserted -> ack exactly 40 WAIT cycles after START with oErr = 1 and oResult = 0.
REQ-041 Done/timeout collision: iAesDone asserted in the cycle where counter == P_TIMEOUT -> oErr = 0, oResult = iAesResult.
REQ-042 Reset in WAIT: iRst pulsed 3 cycles after oStAes -> no ack; next cycle oBusy = 0; late iAesDone ignored; next request served normally.
